// File: rtl/pmem_line_responder_pkg.sv
// Shared types and constants for the pmem line responder.
// Also provides the saturating increment used by the access counters.
package pmem_resp_types;

    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        DONE
    } pmem_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } pmem_op_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pmem_line_responder_if.sv
// 256-bit physical-memory line bus between the initiator and the responder.
interface pmem_line_responder_if;
    import pmem_resp_types::*;

    logic                 pmem_read;
    logic                 pmem_write;
    logic [31:0]          pmem_address;
    logic [LINE_BITS-1:0] pmem_wdata;
    logic [LINE_BITS-1:0] pmem_rdata;
    logic                 pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/pmem_line_responder_array.sv
// Line storage: synchronous write, registered read of the addressed line.
module pmem_line_array
    import pmem_resp_types::*;
#(
    parameter int s_index = 5
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [s_index-1:0]   idx,
    input  logic [LINE_BITS-1:0] wdata,
    output logic [LINE_BITS-1:0] rdata
);

    logic [LINE_BITS-1:0] mem [2**s_index];

    // Contents are deliberately not reset so they survive an aborted access.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/pmem_line_responder.sv
// Responder end of the pmem line bus: serves each read/write after a fixed
// latency, flags protocol violations and counts completed accesses.
module pmem_line_responder
    import pmem_resp_types::*;
#(
    parameter int s_index    = 5,
    parameter int rd_latency = 4,
    parameter int wr_latency = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pmem_line_responder_if.slave bus,
    output logic                proto_err,
    output logic [31:0]         read_count,
    output logic [31:0]         write_count
);

    localparam int          LINE_ADDR_BITS = 32 - OFFSET_BITS;
    localparam logic [7:0]  RD_LOAD        = 8'(rd_latency - 1);
    localparam logic [7:0]  WR_LOAD        = 8'(wr_latency - 1);

    pmem_state_t                state;
    pmem_state_t                state_next;
    pmem_op_t                   cap_op;
    pmem_op_t                   live_op;
    logic [LINE_ADDR_BITS-1:0]  cap_line;
    logic [LINE_BITS-1:0]       cap_wdata;
    logic [LINE_BITS-1:0]       array_rdata;
    logic [7:0]                 lat_cnt;
    logic                       req;
    logic                       last_wait;
    logic                       mismatch;

    assign req       = bus.pmem_read | bus.pmem_write;
    assign live_op   = bus.pmem_write ? OP_WR : OP_RD;
    assign last_wait = (state == WAIT) && (lat_cnt == 8'd0);

    // A dropped request also counts as a change, since it must be held until resp.
    assign mismatch = (state == WAIT) &&
                      (!req || (live_op != cap_op) ||
                       (bus.pmem_address[31:OFFSET_BITS] != cap_line));

    pmem_line_array #(
        .s_index (s_index)
    ) u_array (
        .clk   (clk),
        .we    (last_wait && (cap_op == OP_WR)),
        .idx   (cap_line[s_index-1:0]),
        .wdata (cap_wdata),
        .rdata (array_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = WAIT;
            WAIT:    if (lat_cnt == 8'd0) state_next = RESP;
            RESP:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.pmem_resp  = (state == RESP);
        bus.pmem_rdata = ((state == RESP) && (cap_op == OP_RD)) ? array_rdata : '0;
    end

    // Capture, latency countdown, sticky error flag and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_op      <= OP_RD;
            cap_line    <= '0;
            cap_wdata   <= '0;
            lat_cnt     <= 8'd0;
            proto_err   <= 1'b0;
            read_count  <= 32'd0;
            write_count <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_op    <= live_op;
                        cap_line  <= bus.pmem_address[31:OFFSET_BITS];
                        cap_wdata <= bus.pmem_wdata;
                        lat_cnt   <= (live_op == OP_WR) ? WR_LOAD : RD_LOAD;
                        if (bus.pmem_read && bus.pmem_write) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt != 8'd0) begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                    if (mismatch) begin
                        proto_err <= 1'b1;
                    end
                end
                RESP: begin
                    if (cap_op == OP_WR) begin
                        write_count <= sat_inc(write_count);
                    end else begin
                        read_count <= sat_inc(read_count);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench: two responders (latencies 4/4 and 1/7) driven from a
// vector table plus hand sequences, with a scoreboard checking every resp.
module tb_pmem_line_responder;

    typedef struct {
        int           dut;
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] exp_rdata;
        int           lat;
    } vec_t;

    typedef struct {
        int           dut;
        int           cycle;
        logic [255:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        perr0, perr1;
    logic [31:0] rc0, wc0, rc1, wc1;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic        post_resp[2];
    logic        resp_v[2];
    logic [255:0] rdata_v[2];

    logic [255:0] line_a5, line_x, line_p, line_b, line_z, line_q, line_r, line_s;

    pmem_line_responder_if bus0();
    pmem_line_responder_if bus1();

    pmem_line_responder #(.s_index(5), .rd_latency(4), .wr_latency(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .proto_err(perr0), .read_count(rc0), .write_count(wc0)
    );

    pmem_line_responder #(.s_index(5), .rd_latency(1), .wr_latency(7)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .proto_err(perr1), .read_count(rc1), .write_count(wc1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign resp_v[0]  = bus0.pmem_resp;
    assign resp_v[1]  = bus1.pmem_resp;
    assign rdata_v[0] = bus0.pmem_rdata;
    assign rdata_v[1] = bus1.pmem_rdata;

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each resp pops one expectation; the following cycle must be quiet again.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (post_resp[d] === 1'b1) begin
                check_output("resp_one_cycle", 256'(resp_v[d]), 256'd0);
                check_output("rdata_cleared", rdata_v[d], 256'd0);
            end
            post_resp[d] <= resp_v[d];
            if (resp_v[d] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL unexpected_resp: dut %0d at cycle %0d, none required", d, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("resp_dut", 256'(d), 256'(e.dut));
                    check_output("resp_cycle", 256'(cyc), 256'(e.cycle));
                    check_output("resp_rdata", rdata_v[d], e.rdata);
                end
            end
        end
    end

    task automatic drive(input int d, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [255:0] wd);
        if (d == 0) begin
            bus0.pmem_read = rd; bus0.pmem_write = wr;
            bus0.pmem_address = a; bus0.pmem_wdata = wd;
        end else begin
            bus1.pmem_read = rd; bus1.pmem_write = wr;
            bus1.pmem_address = a; bus1.pmem_wdata = wd;
        end
    endtask

    task automatic push_exp(input int d, input int cycle, input logic [255:0] rdata);
        exp_t e;
        e.dut = d;
        e.cycle = cycle;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL resp_timeout: %0d responses outstanding, 0 required", exp_q.size());
            exp_q.delete();
        end
    endtask

    // One complete transaction issued to an idle responder; resp due capture+lat.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        drive(v.dut, v.rd, v.wr, v.addr, v.wdata);
        push_exp(v.dut, cyc + 1 + v.lat, (v.rd && !v.wr) ? v.exp_rdata : 256'd0);
        wait_drain(300);
        drive(v.dut, 1'b0, 1'b0, 32'd0, 256'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, finish required");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t vecs[8];
        int   c;

        line_a5 = {32{8'hA5}};
        line_x  = {8{32'hDEADBEEF}};
        line_p  = {4{64'h0123456789ABCDEF}};
        line_b  = {16{16'h5A3C}};
        line_z  = {32{8'hFF}};
        line_q  = {8{32'hCAFEF00D}};
        line_r  = {8{32'h11112222}};
        line_s  = {8{32'h33334444}};

        vecs[0] = '{0, 1'b0, 1'b1, 32'h0000_0040, line_a5, 256'd0, 4};
        vecs[1] = '{0, 1'b1, 1'b0, 32'h0000_0040, 256'd0, line_a5, 4};
        vecs[2] = '{0, 1'b0, 1'b1, 32'h0000_0020, line_x, 256'd0, 4};
        vecs[3] = '{0, 1'b1, 1'b0, 32'h0000_043F, 256'd0, line_x, 4};
        vecs[4] = '{0, 1'b0, 1'b1, 32'h0000_0080, line_p, 256'd0, 4};
        vecs[5] = '{0, 1'b1, 1'b0, 32'h0000_0080, 256'd0, line_p, 4};
        vecs[6] = '{1, 1'b0, 1'b1, 32'h0000_0040, line_b, 256'd0, 7};
        vecs[7] = '{1, 1'b1, 1'b0, 32'h0000_0040, 256'd0, line_b, 1};

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 256'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 256'd0);
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_resp0", 256'(bus0.pmem_resp), 256'd0);
        check_output("reset_rdata0", bus0.pmem_rdata, 256'd0);
        check_output("reset_perr0", 256'(perr0), 256'd0);
        check_output("reset_rc0", 256'(rc0), 256'd0);
        check_output("reset_wc0", 256'(wc0), 256'd0);
        check_output("reset_resp1", 256'(bus1.pmem_resp), 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
        end
        #1;
        check_output("table_wc0", 256'(wc0), 256'd3);
        check_output("table_rc0", 256'(rc0), 256'd3);
        check_output("table_wc1", 256'(wc1), 256'd1);
        check_output("table_rc1", 256'(rc1), 256'd1);
        check_output("table_perr0", 256'(perr0), 256'd0);

        // Write to 0x80 aborted by reset just before its commit edge.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h0000_0080, line_z);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("abort_resp", 256'(bus0.pmem_resp), 256'd0);
        check_output("abort_rdata", bus0.pmem_rdata, 256'd0);
        check_output("abort_rc0", 256'(rc0), 256'd0);
        check_output("abort_wc0", 256'(wc0), 256'd0);
        check_output("abort_perr0", 256'(perr0), 256'd0);
        drive(0, 1'b0, 1'b0, 32'd0, 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        apply_stimulus('{0, 1'b1, 1'b0, 32'h0000_0080, 256'd0, line_p, 4});

        // Read and write together behave as a write and latch the error.
        apply_stimulus('{0, 1'b1, 1'b1, 32'h0000_0060, line_q, 256'd0, 4});
        #1;
        check_output("both_perr", 256'(perr0), 256'd1);
        apply_stimulus('{0, 1'b1, 1'b0, 32'h0000_0060, 256'd0, line_q, 4});
        #1;
        check_output("both_wc0", 256'(wc0), 256'd1);
        check_output("perr_sticky", 256'(perr0), 256'd1);

        reset_pulse();
        #1;
        check_output("perr_cleared", 256'(perr0), 256'd0);
        apply_stimulus('{0, 1'b0, 1'b1, 32'h0000_0100, line_r, 256'd0, 4});
        apply_stimulus('{0, 1'b0, 1'b1, 32'h0000_0120, line_s, 256'd0, 4});
        #1;
        check_output("pre_change_perr", 256'(perr0), 256'd0);

        // Address moves to 0x120 mid-WAIT; the captured 0x100 read completes.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h0000_0100, 256'd0);
        push_exp(0, cyc + 5, line_r);
        repeat (2) @(negedge clk);
        bus0.pmem_address = 32'h0000_0120;
        wait_drain(100);
        drive(0, 1'b0, 1'b0, 32'd0, 256'd0);
        repeat (2) @(negedge clk);
        #1;
        check_output("addr_change_perr", 256'(perr0), 256'd1);

        // Held read: pulses every latency+3 cycles, i.e. latency+2 dead cycles between.
        reset_pulse();
        drive(0, 1'b1, 1'b0, 32'h0000_0040, 256'd0);
        c = cyc;
        push_exp(0, c + 5, line_a5);
        push_exp(0, c + 12, line_a5);
        push_exp(0, c + 19, line_a5);
        wait_drain(200);
        drive(0, 1'b0, 1'b0, 32'd0, 256'd0);
        repeat (3) @(negedge clk);
        #1;
        check_output("b2b_rc0", 256'(rc0), 256'd3);
        check_output("b2b_wc0", 256'(wc0), 256'd0);
        check_output("b2b_perr0", 256'(perr0), 256'd0);
        check_output("final_perr1", 256'(perr1), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
